cpu_state_sequencer: RTL and testbench
======================================

Name: cpu_state_sequencer

Overview:
Multicycle state sequencer for the MIPS-subset CPU. It generates the 4-bit state code consumed by the control unit: 0 HALT, 1 FETCH, 2 DECODE, 3 EXEC1, 4 EXEC2.
- Stalls on memory wait-request.
- Skips EXEC2 for instructions that finish early.
- Detects program end, illegal opcodes and memory stall timeouts.
- Provides retire and stall counters for the testbench and performance checks.

Parameters:
CNT_W, 32, width of instr_count and stall_count
MAX_STALL, 255, consecutive stall cycles tolerated before timeout; must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  leave HALT and begin fetching; sampled only in HALT
opcode  input  6  instr[31:26] from the instruction register; valid from EXEC1 onward
mem_waitrequest  input  1  memory not ready; current access must be held
pc_next_zero  input  1  next PC equals 0x00000000; sampled at retire
state  output  4  current state code
active  output  1  1 whenever state != HALT
retire  output  1  one-cycle pulse on the last cycle of each instruction
instr_count  output  CNT_W  retired instruction count
stall_count  output  CNT_W  total wait-request stall cycles
illegal_op  output  1  sticky flag: unsupported opcode decoded
timeout  output  1  sticky flag: memory stall limit exceeded

Behaviour:
- Reset, asynchronous on rst_n low: state=0 (HALT), active=0, retire=0, instr_count=0, stall_count=0, illegal_op=0, timeout=0. Reset mid-instruction abandons it with no retire.
- All other updates occur on the rising edge of clk. State is registered; active and retire are combinational from state and inputs.
- Supported opcodes:
  - Long class, uses EXEC2: 000000 (R), 100011 (lw), 101011 (sw), 000011 (jal).
  - Short class, ends in EXEC1: 000100 (beq), 000010 (j).
- Stall condition (mem_waitrequest=1 in any of these holds the state):
  - FETCH: always.
  - EXEC1: only when opcode=lw.
  - EXEC2: only when opcode=sw.
- Transitions:
  - HALT: start=1 -> FETCH, and clear illegal_op and timeout. Otherwise stay. start outside HALT is ignored.
  - FETCH: stall -> stay. Else -> DECODE.
  - DECODE -> EXEC1 unconditionally. There is no opcode check here.
  - EXEC1:
    - Unsupported opcode -> HALT, set illegal_op, no retire.
    - Stall -> stay.
    - Long class -> EXEC2.
    - Short class -> retire; then HALT if pc_next_zero=1, else FETCH.
  - EXEC2: stall -> stay. Else retire; then HALT if pc_next_zero=1, else FETCH.
- Instruction latency with no stalls: long class 4 cycles (FETCH, DECODE, EXEC1, EXEC2); short class 3 cycles.
- retire = 1 in a cycle that leaves EXEC1 (short class) or EXEC2 without stalling. instr_count increments on that edge.
- stall_count increments every stalled cycle. Both counters wrap modulo 2^CNT_W and are cleared only by reset.
- Timeout watchdog:
  - An internal run counter counts consecutive stalled cycles and clears on any non-stalled cycle.
  - When a stall occurs with run counter == MAX_STALL-1 (the MAX_STALL-th consecutive stall cycle), the next state is HALT and timeout is set. No retire occurs.
  - That cycle still counts in stall_count.
- Simultaneous events:
  - illegal opcode takes priority over stall in EXEC1.
  - timeout takes priority over the normal stalled hold.
  - pc_next_zero is ignored except in the retire cycle.
- Illegal opcode decoding looks only at opcode. Any 6-bit value outside the six listed opcodes is illegal.

Test Plan:
- Reset, then start=1 for 1 cycle, then R-type opcode 000000 with waitrequest=0 and pc_next_zero=0. Required: state sequence 1,2,3,4,1; retire pulses in the EXEC2 cycle; instr_count=1.
- beq 000100 followed by j 000010 with pc_next_zero=1 on the j retire. Required: states 1,2,3,1,2,3,0; instr_count=2; active=0 after the final edge.
- lw with waitrequest=1 for 3 cycles in FETCH and 2 cycles in EXEC1. Required: FETCH held 4 cycles, EXEC1 held 3 cycles; stall_count=5; one retire.
- sw with waitrequest=1 in EXEC1 and 0 in EXEC2. Required: no stall in EXEC1, since sw is not lw. Then waitrequest=1 for 2 cycles in EXEC2 gives stall_count=2.
- Opcode 111111 in EXEC1. Required: next state 0 and illegal_op=1 with instr_count unchanged. A following start=1 clears illegal_op and gives state=1.
- MAX_STALL=4 with waitrequest stuck at 1 in FETCH. Required: state 0 and timeout=1 after the 4th stalled cycle; stall_count=4. rst_n low mid-EXEC2 then gives state=0 immediately and all counters 0.

Source files
------------

// File: rtl/cpu_state_sequencer.sv
// Multicycle state sequencer for the MIPS-subset CPU.
// Produces the state code for the control unit (0 HALT, 1 FETCH, 2 DECODE,
// 3 EXEC1, 4 EXEC2), holds on memory wait-request, skips EXEC2 for short
// instructions, and flags illegal opcodes and memory stall timeouts.
module cpu_state_sequencer #(
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             mem_waitrequest,
    input  logic             pc_next_zero,
    output logic [3:0]       state,
    output logic             active,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] stall_count,
    output logic             illegal_op,
    output logic             timeout
);

    // Run counter only has to reach MAX_STALL-1 before the watchdog fires.
    localparam int RUN_W = (MAX_STALL > 1) ? $clog2(MAX_STALL) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_STALL - 1);

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    typedef enum logic [3:0] {
        ST_HALT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC1  = 4'd3,
        ST_EXEC2  = 4'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               illegal_op_q, illegal_op_d;
    logic               timeout_q, timeout_d;

    logic               is_long_s;
    logic               is_short_s;
    logic               stall_s;
    logic               timeout_hit_s;
    logic               retire_s;

    // Opcode classification: long class runs through EXEC2, short ends in EXEC1.
    always_comb begin
        is_long_s  = 1'b0;
        is_short_s = 1'b0;
        case (opcode)
            OP_R, OP_LW, OP_SW, OP_JAL: is_long_s  = 1'b1;
            OP_BEQ, OP_J:               is_short_s = 1'b1;
            default: begin
                is_long_s  = 1'b0;
                is_short_s = 1'b0;
            end
        endcase
    end

    // A stall holds only the accesses that actually touch memory in that state.
    always_comb begin
        stall_s = 1'b0;
        case (state_q)
            ST_FETCH: stall_s = mem_waitrequest;
            ST_EXEC1: stall_s = mem_waitrequest && (opcode == OP_LW);
            ST_EXEC2: stall_s = mem_waitrequest && (opcode == OP_SW);
            default:  stall_s = 1'b0;
        endcase
        timeout_hit_s = stall_s && (run_q == RUN_LAST);
    end

    // Next-state, watchdog, counters and sticky flags.
    always_comb begin
        state_d       = state_q;
        instr_count_d = instr_count_q;
        stall_count_d = stall_count_q;
        run_d         = run_q;
        illegal_op_d  = illegal_op_q;
        timeout_d     = timeout_q;
        retire_s      = 1'b0;

        // Every stalled cycle counts, including the one that trips the watchdog.
        if (stall_s) begin
            stall_count_d = stall_count_q + CNT_W'(1);
            if (timeout_hit_s) begin
                run_d = '0;
            end else begin
                run_d = run_q + RUN_W'(1);
            end
        end else begin
            run_d = '0;
        end

        case (state_q)
            ST_HALT: begin
                if (start) begin
                    state_d      = ST_FETCH;
                    illegal_op_d = 1'b0;
                    timeout_d    = 1'b0;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_FETCH: begin
                if (timeout_hit_s) begin
                    state_d   = ST_HALT;
                    timeout_d = 1'b1;
                end else if (stall_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC1;
            end
            ST_EXEC1: begin
                // Illegal opcode wins over any stall in this state.
                if (!is_long_s && !is_short_s) begin
                    state_d      = ST_HALT;
                    illegal_op_d = 1'b1;
                end else if (timeout_hit_s) begin
                    state_d   = ST_HALT;
                    timeout_d = 1'b1;
                end else if (stall_s) begin
                    state_d = ST_EXEC1;
                end else if (is_long_s) begin
                    state_d = ST_EXEC2;
                end else begin
                    retire_s = 1'b1;
                    state_d  = pc_next_zero ? ST_HALT : ST_FETCH;
                end
            end
            ST_EXEC2: begin
                if (timeout_hit_s) begin
                    state_d   = ST_HALT;
                    timeout_d = 1'b1;
                end else if (stall_s) begin
                    state_d = ST_EXEC2;
                end else begin
                    retire_s = 1'b1;
                    state_d  = pc_next_zero ? ST_HALT : ST_FETCH;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        if (retire_s) begin
            instr_count_d = instr_count_q + CNT_W'(1);
        end else begin
            instr_count_d = instr_count_q;
        end
    end

    // State, counters and flags; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HALT;
            instr_count_q <= '0;
            stall_count_q <= '0;
            run_q         <= '0;
            illegal_op_q  <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
            stall_count_q <= stall_count_d;
            run_q         <= run_d;
            illegal_op_q  <= illegal_op_d;
            timeout_q     <= timeout_d;
        end
    end

    assign state       = state_q;
    assign active      = (state_q != ST_HALT);
    assign retire      = retire_s;
    assign instr_count = instr_count_q;
    assign stall_count = stall_count_q;
    assign illegal_op  = illegal_op_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_cpu_state_sequencer.sv
// Self-checking bench for cpu_state_sequencer: directed vector table,
// hand-written corner sequences and randomized traffic against a reference model.
module tb_cpu_state_sequencer;

    localparam int MAX_ST = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  opcode;
    logic        mem_waitrequest;
    logic        pc_next_zero;
    logic [3:0]  state;
    logic        active;
    logic        retire;
    logic [31:0] instr_count;
    logic [31:0] stall_count;
    logic        illegal_op;
    logic        timeout;

    cpu_state_sequencer #(.CNT_W(32), .MAX_STALL(MAX_ST)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .mem_waitrequest(mem_waitrequest), .pc_next_zero(pc_next_zero),
        .state(state), .active(active), .retire(retire),
        .instr_count(instr_count), .stall_count(stall_count),
        .illegal_op(illegal_op), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: state code plus architectural counters and flags.
    int          m_state;
    logic [31:0] m_instr;
    logic [31:0] m_stall;
    int          m_run;
    logic        m_ill;
    logic        m_to;

    // Values captured at the sampling point of the last cycle.
    logic [3:0]  snap_state;
    logic        snap_ret;
    logic        snap_act;
    logic [31:0] snap_ic;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // 2 = long class, 1 = short class, 0 = illegal
    function automatic int op_class(input logic [5:0] op);
        case (op)
            6'd0, 6'd35, 6'd43, 6'd3: return 2;
            6'd4, 6'd2:               return 1;
            default:                  return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_instr = 32'd0; m_stall = 32'd0;
        m_run = 0; m_ill = 1'b0; m_to = 1'b0;
    endtask

    // One clock cycle: drive inputs, check against model, advance model.
    task automatic cyc(input logic s, input logic [5:0] op, input logic w, input logic pz);
        int   cl;
        bit   stl;
        bit   r;
        int   n_state;
        int   n_run;
        logic [31:0] n_instr;
        logic [31:0] n_stall;
        logic n_ill;
        logic n_to;
        start = s; opcode = op; mem_waitrequest = w; pc_next_zero = pz;
        cl  = op_class(op);
        stl = w && (m_state == 1 || (m_state == 3 && op == 6'd35) || (m_state == 4 && op == 6'd43));
        r = 1'b0;
        n_state = m_state; n_run = m_run; n_instr = m_instr; n_stall = m_stall;
        n_ill = m_ill; n_to = m_to;
        if (m_state == 0) begin
            n_run = 0;
            if (s) begin n_state = 1; n_ill = 1'b0; n_to = 1'b0; end
        end else if (m_state == 3 && cl == 0) begin
            n_state = 0; n_ill = 1'b1; n_run = 0;
        end else if (stl) begin
            n_stall = m_stall + 32'd1;
            if (m_run == MAX_ST - 1) begin
                n_state = 0; n_to = 1'b1; n_run = 0;
            end else begin
                n_run = m_run + 1;
            end
        end else begin
            n_run = 0;
            if (m_state == 1)                 n_state = 2;
            else if (m_state == 2)            n_state = 3;
            else if (m_state == 3 && cl == 2) n_state = 4;
            else begin
                r = 1'b1;
                n_instr = m_instr + 32'd1;
                n_state = pz ? 0 : 1;
            end
        end
        @(negedge clk);
        chk("state",       {28'd0, state},       32'(m_state));
        chk("active",      {31'd0, active},      {31'd0, (m_state != 0)});
        chk("retire",      {31'd0, retire},      {31'd0, r});
        chk("instr_count", instr_count,          m_instr);
        chk("stall_count", stall_count,          m_stall);
        chk("illegal_op",  {31'd0, illegal_op},  {31'd0, m_ill});
        chk("timeout",     {31'd0, timeout},     {31'd0, m_to});
        snap_state = state; snap_ret = retire; snap_act = active; snap_ic = instr_count;
        @(posedge clk);
        #1;
        m_state = n_state; m_run = n_run; m_instr = n_instr; m_stall = n_stall;
        m_ill = n_ill; m_to = n_to;
    endtask

    typedef struct {
        logic        s;
        logic [5:0]  op;
        logic        w;
        logic        pz;
        logic [3:0]  e_state;
        logic        e_ret;
        logic [31:0] e_ic;
    } vec_t;

    vec_t vecs[12];
    logic [5:0] cur_op;
    logic [5:0] op_pool[7];

    initial begin
        // R-type, then beq and j ending with pc_next_zero on the j retire.
        vecs[0]  = '{1'b1, 6'd0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0};
        vecs[1]  = '{1'b0, 6'd0, 1'b0, 1'b0, 4'd1, 1'b0, 32'd0};
        vecs[2]  = '{1'b0, 6'd0, 1'b0, 1'b0, 4'd2, 1'b0, 32'd0};
        vecs[3]  = '{1'b0, 6'd0, 1'b0, 1'b0, 4'd3, 1'b0, 32'd0};
        vecs[4]  = '{1'b0, 6'd0, 1'b0, 1'b0, 4'd4, 1'b1, 32'd0};
        vecs[5]  = '{1'b0, 6'd4, 1'b0, 1'b0, 4'd1, 1'b0, 32'd1};
        vecs[6]  = '{1'b0, 6'd4, 1'b0, 1'b0, 4'd2, 1'b0, 32'd1};
        vecs[7]  = '{1'b0, 6'd4, 1'b0, 1'b0, 4'd3, 1'b1, 32'd1};
        vecs[8]  = '{1'b0, 6'd2, 1'b0, 1'b0, 4'd1, 1'b0, 32'd2};
        vecs[9]  = '{1'b0, 6'd2, 1'b0, 1'b0, 4'd2, 1'b0, 32'd2};
        vecs[10] = '{1'b0, 6'd2, 1'b0, 1'b1, 4'd3, 1'b1, 32'd2};
        vecs[11] = '{1'b0, 6'd0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd3};
        op_pool = '{6'd0, 6'd35, 6'd43, 6'd3, 6'd4, 6'd2, 6'd63};

        rst_n = 1'b0; start = 1'b0; opcode = 6'd0; mem_waitrequest = 1'b0; pc_next_zero = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_state", {28'd0, state}, 32'd0);
        chk("rst_active", {31'd0, active}, 32'd0);
        chk("rst_counts", instr_count | stall_count, 32'd0);
        chk("rst_flags", {30'd0, illegal_op, timeout}, 32'd0);
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            cyc(vecs[i].s, vecs[i].op, vecs[i].w, vecs[i].pz);
            chk("vec_state",  {28'd0, snap_state}, {28'd0, vecs[i].e_state});
            chk("vec_retire", {31'd0, snap_ret},   {31'd0, vecs[i].e_ret});
            chk("vec_active", {31'd0, snap_act},   {31'd0, (vecs[i].e_state != 4'd0)});
            chk("vec_icount", snap_ic,             vecs[i].e_ic);
        end
        chk("beqj_halt", {31'd0, active}, 32'd0);

        // lw: 3 stalls in FETCH, 2 in EXEC1.
        cyc(1'b1, 6'd35, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 6'd35, 1'b1, 1'b0);
        cyc(1'b0, 6'd35, 1'b0, 1'b0);
        chk("lw_fetch_done", {28'd0, state}, 32'd2);
        cyc(1'b0, 6'd35, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 6'd35, 1'b1, 1'b0);
        chk("lw_exec1_held", {28'd0, state}, 32'd3);
        cyc(1'b0, 6'd35, 1'b0, 1'b0);
        cyc(1'b0, 6'd35, 1'b0, 1'b1);
        chk("lw_stalls", stall_count, 32'd5);
        chk("lw_retired", instr_count, 32'd4);

        // sw: waitrequest in EXEC1 is not a stall; 2 stalls in EXEC2.
        cyc(1'b1, 6'd43, 1'b0, 1'b0);
        cyc(1'b0, 6'd43, 1'b0, 1'b0);
        cyc(1'b0, 6'd43, 1'b0, 1'b0);
        cyc(1'b0, 6'd43, 1'b1, 1'b0);
        chk("sw_no_exec1_stall", {28'd0, state}, 32'd4);
        repeat (2) cyc(1'b0, 6'd43, 1'b1, 1'b0);
        cyc(1'b0, 6'd43, 1'b0, 1'b1);
        chk("sw_stalls", stall_count, 32'd7);

        // Illegal opcode, then start clears the flag.
        cyc(1'b1, 6'd63, 1'b0, 1'b0);
        cyc(1'b0, 6'd63, 1'b0, 1'b0);
        cyc(1'b0, 6'd63, 1'b0, 1'b0);
        cyc(1'b0, 6'd63, 1'b1, 1'b0);
        chk("ill_state", {28'd0, state}, 32'd0);
        chk("ill_flag", {31'd0, illegal_op}, 32'd1);
        chk("ill_icount", instr_count, 32'd5);
        cyc(1'b1, 6'd0, 1'b0, 1'b0);
        chk("ill_cleared", {31'd0, illegal_op}, 32'd0);
        chk("ill_restart", {28'd0, state}, 32'd1);

        // Watchdog: waitrequest stuck in FETCH.
        repeat (3) cyc(1'b0, 6'd0, 1'b1, 1'b0);
        chk("to_not_yet", {28'd0, state}, 32'd1);
        cyc(1'b0, 6'd0, 1'b1, 1'b0);
        chk("to_state", {28'd0, state}, 32'd0);
        chk("to_flag", {31'd0, timeout}, 32'd1);
        chk("to_stalls", stall_count, 32'd11);

        // Reset in the middle of EXEC2.
        cyc(1'b1, 6'd0, 1'b0, 1'b0);
        chk("to_cleared", {31'd0, timeout}, 32'd0);
        cyc(1'b0, 6'd0, 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 1'b0, 1'b0);
        chk("pre_rst_exec2", {28'd0, state}, 32'd4);
        rst_n = 1'b0;
        #1;
        chk("midrst_state", {28'd0, state}, 32'd0);
        chk("midrst_retire", {31'd0, retire}, 32'd0);
        chk("midrst_icount", instr_count, 32'd0);
        chk("midrst_scount", stall_count, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic against the model.
        cur_op = 6'd0;
        for (int i = 0; i < 3000; i++) begin
            logic s, w, pz;
            if (m_state <= 1) begin
                if ($urandom_range(0, 7) == 7) cur_op = 6'($urandom_range(0, 63));
                else cur_op = op_pool[$urandom_range(0, 6)];
            end
            s  = ($urandom_range(0, 3) != 0);
            w  = ($urandom_range(0, 99) < 40);
            pz = ($urandom_range(0, 9) == 0);
            cyc(s, cur_op, w, pz);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
